// File: rtl/cpu_jtag_debug_cmd_sync_if.sv
// Command-path bundle between the JTAG debug front end and its clk-domain consumer.
// master drives the JTAG-side inputs and consumer handshake, slave is the synchroniser.
interface cpu_jtag_debug_cmd_sync_if #(
  parameter int DR_WIDTH   = 38,
  parameter int IR_WIDTH   = 2,
  parameter int FIFO_DEPTH = 4
);
  localparam int LEVEL_W = $clog2(FIFO_DEPTH) + 1;

  logic [DR_WIDTH-1:0] sr;
  logic [IR_WIDTH-1:0] ir_in;
  logic                vs_udr;
  logic                vs_uir;
  logic                cmd_ready;
  logic                ovf_clr;
  logic                cmd_valid;
  logic [IR_WIDTH-1:0] cmd_ir;
  logic [DR_WIDTH-1:0] jdo;
  logic                cmd_action;
  logic                uir_pulse;
  logic                overflow;
  logic [LEVEL_W-1:0]  fifo_level;

  modport master (
    output sr, ir_in, vs_udr, vs_uir, cmd_ready, ovf_clr,
    input  cmd_valid, cmd_ir, jdo, cmd_action, uir_pulse, overflow, fifo_level
  );

  modport slave (
    input  sr, ir_in, vs_udr, vs_uir, cmd_ready, ovf_clr,
    output cmd_valid, cmd_ir, jdo, cmd_action, uir_pulse, overflow, fifo_level
  );
endinterface

// File: rtl/cpu_jtag_debug_cmd_sync.sv
// Brings the JTAG update-DR/update-IR levels into the clk domain and queues
// {ir, dr} commands for a ready/valid consumer, with sticky overflow on drops.
module cpu_jtag_debug_cmd_sync #(
  parameter int DR_WIDTH    = 38,
  parameter int IR_WIDTH    = 2,
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input logic clk,
  input logic reset,
  cpu_jtag_debug_cmd_sync_if.slave bus
);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int LW    = AW + 1;
  localparam int CW    = IR_WIDTH + DR_WIDTH;
  localparam int ARM_W = $clog2(SYNC_STAGES + 2);
  localparam logic [ARM_W-1:0] ARM_LOAD = ARM_W'(SYNC_STAGES + 1);
  localparam logic [LW-1:0]    DEPTH    = LW'(FIFO_DEPTH);

  logic [SYNC_STAGES-1:0] udr_sync_reg;
  logic [SYNC_STAGES-1:0] uir_sync_reg;
  logic                   udr_dly_reg;
  logic                   uir_dly_reg;
  logic [ARM_W-1:0]       arm_cnt_reg;
  logic [CW-1:0]          mem [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr_reg;
  logic [AW-1:0]          rd_ptr_reg;
  logic [LW-1:0]          count_reg;
  logic [CW-1:0]          head_reg;
  logic                   uir_pulse_reg;
  logic                   overflow_reg;

  logic          armed;
  logic          udr_rise;
  logic          uir_rise;
  logic          full;
  logic          empty;
  logic          pop;
  logic          push;
  logic          drop;
  logic [AW-1:0] rd_inc;
  logic [CW-1:0] push_data;

  // Edges are ignored until the chains have flushed, so a level held through reset is not an event.
  assign armed     = (arm_cnt_reg == '0);
  assign udr_rise  = armed & udr_sync_reg[SYNC_STAGES-1] & ~udr_dly_reg;
  assign uir_rise  = armed & uir_sync_reg[SYNC_STAGES-1] & ~uir_dly_reg;
  assign full      = (count_reg == DEPTH);
  assign empty     = (count_reg == '0);
  assign pop       = ~empty & bus.cmd_ready;
  assign push      = udr_rise & (~full | pop);
  assign drop      = udr_rise & full & ~pop;
  assign rd_inc    = rd_ptr_reg + AW'(1);
  assign push_data = {bus.ir_in, bus.sr};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      udr_sync_reg  <= '0;
      uir_sync_reg  <= '0;
      udr_dly_reg   <= 1'b0;
      uir_dly_reg   <= 1'b0;
      arm_cnt_reg   <= ARM_LOAD;
      uir_pulse_reg <= 1'b0;
      overflow_reg  <= 1'b0;
    end else begin
      udr_sync_reg  <= {udr_sync_reg[SYNC_STAGES-2:0], bus.vs_udr};
      uir_sync_reg  <= {uir_sync_reg[SYNC_STAGES-2:0], bus.vs_uir};
      udr_dly_reg   <= udr_sync_reg[SYNC_STAGES-1];
      uir_dly_reg   <= uir_sync_reg[SYNC_STAGES-1];
      if (!armed) begin
        arm_cnt_reg <= arm_cnt_reg - ARM_W'(1);
      end
      uir_pulse_reg <= uir_rise;
      if (drop) begin
        overflow_reg <= 1'b1;
      end else if (bus.ovf_clr) begin
        overflow_reg <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // head_reg mirrors the front entry so the outputs keep the last popped command once empty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      head_reg   <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_inc;
      end
      if (push && !pop) begin
        count_reg <= count_reg + LW'(1);
      end else if (pop && !push) begin
        count_reg <= count_reg - LW'(1);
      end
      if (pop) begin
        if (count_reg > LW'(1)) begin
          head_reg <= mem[rd_inc];
        end else if (push) begin
          head_reg <= push_data;
        end
      end else if (push && empty) begin
        head_reg <= push_data;
      end
    end
  end

  assign bus.cmd_valid  = ~empty;
  assign bus.cmd_ir     = head_reg[CW-1:DR_WIDTH];
  assign bus.jdo        = head_reg[DR_WIDTH-1:0];
  assign bus.cmd_action = head_reg[DR_WIDTH-1];
  assign bus.uir_pulse  = uir_pulse_reg;
  assign bus.overflow   = overflow_reg;
  assign bus.fifo_level = count_reg;
endmodule

// File: tb/tb_cpu_jtag_debug_cmd_sync.sv
// Randomised bench for cpu_jtag_debug_cmd_sync: a queue-level reference model
// feeds a scoreboard that a negedge monitor drains on every handshake.
`timescale 1ns/1ps
module tb_cpu_jtag_debug_cmd_sync;
  localparam int DR_WIDTH    = 38;
  localparam int IR_WIDTH    = 2;
  localparam int SYNC_STAGES = 2;
  localparam int FIFO_DEPTH  = 4;
  localparam int CW          = DR_WIDTH + IR_WIDTH;

  logic clk = 1'b0;
  logic reset = 1'b1;

  cpu_jtag_debug_cmd_sync_if #(
    .DR_WIDTH(DR_WIDTH), .IR_WIDTH(IR_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)
  ) bus ();

  cpu_jtag_debug_cmd_sync #(
    .DR_WIDTH(DR_WIDTH), .IR_WIDTH(IR_WIDTH),
    .SYNC_STAGES(SYNC_STAGES), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a command lands SYNC_STAGES edges after the first edge that
  // samples the level high; occupancy decides accept/drop; accepted commands go to the scoreboard.
  int            edge_no = 0;
  int            push_at = -1;
  int            uir_at  = -1;
  int            m_level = 0;
  bit            prev_udr = 1'b0;
  bit            prev_uir = 1'b0;
  bit            exp_ovf = 1'b0;
  bit            exp_uir = 1'b0;
  bit            m_pop;
  logic [CW-1:0] sb_q[$];

  initial forever begin
    @(posedge clk);
    edge_no++;
    if (reset) begin
      m_level = 0;
      sb_q.delete();
      exp_ovf = 1'b0;
      exp_uir = 1'b0;
      push_at = -1;
      uir_at  = -1;
      prev_udr = bus.vs_udr;
      prev_uir = bus.vs_uir;
    end else begin
      m_pop = (m_level > 0) && bus.cmd_ready;
      if (m_pop) m_level--;
      exp_uir = (edge_no == uir_at);
      if (edge_no == push_at) begin
        if (m_level < FIFO_DEPTH) begin
          m_level++;
          sb_q.push_back({bus.ir_in, bus.sr});
        end else begin
          exp_ovf = 1'b1;
        end
      end else if (bus.ovf_clr) begin
        exp_ovf = 1'b0;
      end
      if (bus.vs_udr && !prev_udr) push_at = edge_no + SYNC_STAGES;
      if (bus.vs_uir && !prev_uir) uir_at = edge_no + SYNC_STAGES;
      prev_udr = bus.vs_udr;
      prev_uir = bus.vs_uir;
    end
  end

  // Monitor: compares status every cycle and pops the scoreboard on each handshake.
  logic [CW-1:0] last_cmd = '0;
  logic [CW-1:0] head;
  int            uir_seen = 0;
  int            pops = 0;

  initial forever begin
    @(negedge clk);
    if (reset) begin
      last_cmd = '0;
    end else begin
      chk("fifo_level", 64'(bus.fifo_level), 64'(m_level));
      chk("cmd_valid", 64'(bus.cmd_valid), 64'(m_level != 0));
      chk("overflow", 64'(bus.overflow), 64'(exp_ovf));
      chk("uir_pulse", 64'(bus.uir_pulse), 64'(exp_uir));
      if (bus.uir_pulse) uir_seen++;
      if (bus.cmd_valid) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_cmd: got jdo=%0h, expected no command (t=%0t)", bus.jdo, $time);
        end else begin
          head = bus.cmd_ready ? sb_q.pop_front() : sb_q[0];
          chk("cmd_data", 64'({bus.cmd_ir, bus.jdo}), 64'(head));
          chk("cmd_action", 64'(bus.cmd_action), 64'(head[DR_WIDTH-1]));
          if (bus.cmd_ready) begin
            last_cmd = head;
            pops++;
            $display("pop %0d: ir=%b jdo=%h action=%b", pops, bus.cmd_ir, bus.jdo, bus.cmd_action);
          end
        end
      end else begin
        chk("hold_last", 64'({bus.cmd_ir, bus.jdo}), 64'(last_cmd));
      end
    end
  end

  bit rand_mode = 1'b0;
  int ready_pct = 50;

  // Each call leaves time at 2 ns past a rising edge.
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
      if (rand_mode) begin
        bus.cmd_ready = ($urandom_range(0, 99) < ready_pct);
        bus.ovf_clr   = ($urandom_range(0, 7) == 0);
      end
    end
  endtask

  task automatic udr_event(input logic [IR_WIDTH-1:0] ir, input logic [DR_WIDTH-1:0] d,
                           input bit uir, input int hi, input int lo);
    bus.ir_in  = ir;
    bus.sr     = d;
    bus.vs_udr = 1'b1;
    bus.vs_uir = uir;
    cyc(hi);
    bus.vs_udr = 1'b0;
    bus.vs_uir = 1'b0;
    cyc(lo);
  endtask

  logic [63:0] rnd;

  initial begin
    bus.sr = '0;
    bus.ir_in = '0;
    bus.vs_udr = 1'b1;
    bus.vs_uir = 1'b1;
    bus.cmd_ready = 1'b0;
    bus.ovf_clr = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 64'(bus.cmd_valid), 64'(0));
    chk("rst_level", 64'(bus.fifo_level), 64'(0));
    chk("rst_jdo", 64'(bus.jdo), 64'(0));
    chk("rst_ir", 64'(bus.cmd_ir), 64'(0));
    chk("rst_action", 64'(bus.cmd_action), 64'(0));
    chk("rst_uir", 64'(bus.uir_pulse), 64'(0));
    chk("rst_ovf", 64'(bus.overflow), 64'(0));
    @(posedge clk);
    #2 reset = 1'b0;
    uir_seen = 0;

    // Levels held high across reset release must not create events.
    cyc(10);
    chk("held_level", 64'(bus.fifo_level), 64'(0));
    chk("held_uir", 64'(uir_seen), 64'(0));
    bus.vs_udr = 1'b0;
    bus.vs_uir = 1'b0;
    cyc(SYNC_STAGES + 3);
    bus.vs_uir = 1'b1;
    cyc(4);
    bus.vs_uir = 1'b0;
    cyc(SYNC_STAGES + 3);
    chk("uir_once", 64'(uir_seen), 64'(1));

    // Single command with consumer ready: latency and immediate pop.
    bus.ir_in = 2'b01;
    bus.sr = 38'h20_0000_00AB;
    bus.vs_udr = 1'b1;
    bus.cmd_ready = 1'b1;
    repeat (SYNC_STAGES) @(posedge clk);
    #1 chk("lat_early", 64'(bus.cmd_valid), 64'(0));
    @(posedge clk);
    #1;
    chk("lat_valid", 64'(bus.cmd_valid), 64'(1));
    chk("lat_ir", 64'(bus.cmd_ir), 64'(2'b01));
    chk("lat_jdo", 64'(bus.jdo), 64'(38'h20_0000_00AB));
    chk("lat_action", 64'(bus.cmd_action), 64'(1));
    @(posedge clk);
    #1;
    chk("lat_popped", 64'(bus.cmd_valid), 64'(0));
    chk("lat_level", 64'(bus.fifo_level), 64'(0));
    #1 bus.vs_udr = 1'b0;
    cyc(SYNC_STAGES + 3);

    // Five commands into a depth-4 queue with no consumer.
    bus.cmd_ready = 1'b0;
    for (int i = 1; i <= 5; i++) udr_event('0, DR_WIDTH'(i), 1'b0, 2, SYNC_STAGES + 1);
    chk("fill_level", 64'(bus.fifo_level), 64'(FIFO_DEPTH));
    chk("fill_ovf", 64'(bus.overflow), 64'(1));
    bus.cmd_ready = 1'b1;
    cyc(6);
    chk("drain_valid", 64'(bus.cmd_valid), 64'(0));

    // Clear, refill, then drop while ovf_clr is high.
    bus.ovf_clr = 1'b1;
    cyc(1);
    bus.ovf_clr = 1'b0;
    chk("clr_ovf", 64'(bus.overflow), 64'(0));
    bus.cmd_ready = 1'b0;
    for (int i = 0; i < FIFO_DEPTH; i++) udr_event(2'b10, DR_WIDTH'(16 + i), 1'b0, 2, SYNC_STAGES + 1);
    bus.ir_in = 2'b11;
    bus.sr = 38'h3F_0000_0099;
    bus.vs_udr = 1'b1;
    bus.ovf_clr = 1'b1;
    cyc(SYNC_STAGES + 1);
    chk("drop_clr_ovf", 64'(bus.overflow), 64'(1));
    cyc(1);
    chk("clr_alone_ovf", 64'(bus.overflow), 64'(0));
    bus.ovf_clr = 1'b0;
    bus.vs_udr = 1'b0;
    cyc(SYNC_STAGES + 1);

    // Full queue, push coincident with a pop: accepted, emerges fourth.
    bus.ir_in = 2'b01;
    bus.sr = 38'h00_0000_003C;
    bus.vs_udr = 1'b1;
    cyc(SYNC_STAGES);
    bus.cmd_ready = 1'b1;
    cyc(1);
    bus.cmd_ready = 1'b0;
    chk("swap_level", 64'(bus.fifo_level), 64'(FIFO_DEPTH));
    chk("swap_ovf", 64'(bus.overflow), 64'(0));
    bus.vs_udr = 1'b0;
    cyc(SYNC_STAGES + 1);
    bus.cmd_ready = 1'b1;
    cyc(8);
    chk("swap_drained", 64'(bus.cmd_valid), 64'(0));

    // Asynchronous reset with three commands queued.
    bus.cmd_ready = 1'b0;
    for (int i = 0; i < 3; i++) udr_event(2'b00, DR_WIDTH'(40 + i), 1'b0, 2, SYNC_STAGES + 1);
    chk("pre_rst_level", 64'(bus.fifo_level), 64'(3));
    #1 reset = 1'b1;
    #1;
    chk("async_rst_valid", 64'(bus.cmd_valid), 64'(0));
    chk("async_rst_level", 64'(bus.fifo_level), 64'(0));
    chk("async_rst_jdo", 64'(bus.jdo), 64'(0));
    cyc(2);
    reset = 1'b0;
    cyc(SYNC_STAGES + 4);

    // Randomised traffic: slow consumer first to provoke drops, then a fast one.
    rand_mode = 1'b1;
    for (int n = 0; n < 80; n++) begin
      ready_pct = (n < 40) ? 15 : 70;
      rnd = {$urandom(), $urandom()};
      udr_event(IR_WIDTH'($urandom()), rnd[DR_WIDTH-1:0], ($urandom_range(0, 2) == 0),
                $urandom_range(1, 3), $urandom_range(SYNC_STAGES, SYNC_STAGES + 4));
    end
    rand_mode = 1'b0;
    bus.cmd_ready = 1'b1;
    bus.ovf_clr = 1'b0;
    cyc(10);
    chk("final_valid", 64'(bus.cmd_valid), 64'(0));
    chk("final_sb_empty", 64'(sb_q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
